// File: rtl/sfu_pool_v2_if.sv
// Control/data bundle for the SFU pooling stage.
// The master drives the qualifiers and psum_in; the slave returns psum_out, out_valid_o and sat_o.
interface sfu_pool_v2_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic                     valid_i;
  logic                     acc_i;
  logic                     flush_i;
  logic                     psum_bypass_i;
  logic                     relu_en_i;
  logic                     max_pool_en_i;
  logic [psum_bw*col-1:0]   psum_in;
  logic [psum_bw*col-1:0]   psum_out;
  logic                     out_valid_o;
  logic                     sat_o;

  modport master (
    output valid_i, acc_i, flush_i, psum_bypass_i, relu_en_i, max_pool_en_i, psum_in,
    input  psum_out, out_valid_o, sat_o
  );

  modport slave (
    input  valid_i, acc_i, flush_i, psum_bypass_i, relu_en_i, max_pool_en_i, psum_in,
    output psum_out, out_valid_o, sat_o
  );
endinterface

// File: rtl/sfu_pool_v2.sv
// Per-channel saturating accumulator with bypass, ReLU and optional POOL_K-window max pooling.
// Results are registered; sat_o is sticky until reset.
module sfu_pool_v2 #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int POOL_K  = 2
) (
  input  logic         clk,
  input  logic         reset,
  sfu_pool_v2_if.slave bus
);
  localparam int CW = (POOL_K > 1) ? $clog2(POOL_K) : 1;
  localparam logic signed [psum_bw-1:0] S_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] S_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  // Returns {clamped, value}: sum formed one bit wider, then clamped to the signed range.
  function automatic logic [psum_bw:0] sat_add(input logic signed [psum_bw-1:0] a,
                                               input logic signed [psum_bw-1:0] b);
    logic [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (s[psum_bw] != s[psum_bw-1])
      sat_add = {1'b1, (s[psum_bw] ? S_MIN : S_MAX)};
    else
      sat_add = {1'b0, s[psum_bw-1:0]};
  endfunction

  logic signed [psum_bw-1:0] acc_q [col];
  logic signed [psum_bw-1:0] max_q [col];
  logic [CW-1:0]             cnt_q;
  logic [psum_bw*col-1:0]    psum_q;
  logic [psum_bw*col-1:0]    out_next;
  logic                      out_valid_q;
  logic                      sat_q;
  logic [col-1:0]            sat_vec;

  logic produce, pool_on, win_first, win_last, acc_upd, sat_any;

  assign produce   = bus.valid_i & (bus.psum_bypass_i | bus.flush_i);
  assign pool_on   = bus.max_pool_en_i;
  assign win_first = (cnt_q == '0);
  assign win_last  = (cnt_q == CW'(POOL_K - 1));
  assign acc_upd   = bus.valid_i & ~bus.psum_bypass_i;
  assign sat_any   = acc_upd & bus.acc_i & (|sat_vec);

  for (genvar c = 0; c < col; c++) begin : g_ch
    logic signed [psum_bw-1:0] in_c, v_raw, v_c, mx_c;
    logic [psum_bw:0]          sa;

    assign in_c  = bus.psum_in[c*psum_bw +: psum_bw];
    assign sa    = sat_add(acc_q[c], in_c);
    assign v_raw = bus.psum_bypass_i ? in_c : (bus.acc_i ? sa[psum_bw-1:0] : acc_q[c]);
    assign v_c   = (bus.relu_en_i && v_raw[psum_bw-1]) ? '0 : v_raw;
    assign mx_c  = (max_q[c] > v_c) ? max_q[c] : v_c;
    assign sat_vec[c] = sa[psum_bw];
    // Window close only happens with cnt_q > 0, so max_q already holds the earlier results.
    assign out_next[c*psum_bw +: psum_bw] = pool_on ? mx_c : v_c;

    always_ff @(posedge clk) begin
      if (reset) begin
        acc_q[c] <= '0;
        max_q[c] <= '0;
      end else begin
        if (acc_upd) begin
          if (bus.flush_i)    acc_q[c] <= '0;
          else if (bus.acc_i) acc_q[c] <= sa[psum_bw-1:0];
        end
        if (produce && pool_on)
          max_q[c] <= win_first ? v_c : mx_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      psum_q      <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (sat_any) sat_q <= 1'b1;
      if (bus.valid_i) begin
        if (!pool_on) cnt_q <= '0;
        if (produce) begin
          if (!pool_on || win_last) begin
            psum_q      <= out_next;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      end
    end
  end

  assign bus.psum_out    = psum_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.sat_o       = sat_q;
endmodule

// File: tb/tb_sfu_pool_v2.sv
// Table-driven bench for sfu_pool_v2: rows carry stimulus and expected outputs; results
// expected from a row are queued on drive and popped when out_valid_o is seen.
module tb_sfu_pool_v2;
  localparam int COL = 8;
  localparam int BW  = 16;

  typedef logic [COL*BW-1:0] vec_w;

  typedef struct {
    logic        rst, vld, acc, fl, by, re, po;
    logic [15:0] in0, in1;
    logic        ev;
    logic [15:0] e0, e1;
    logic        es;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sfu_pool_v2_if #(.col(COL), .psum_bw(BW)) bus ();
  sfu_pool_v2 #(.col(COL), .psum_bw(BW), .POOL_K(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  int   errors = 0;
  int   checks = 0;
  vec_w sb [$];
  vec_w last_out = '0;
  vec_t vecs [$];

  function automatic vec_w mk(input logic [15:0] a, input logic [15:0] b);
    vec_w v;
    for (int c = 0; c < COL; c++) v[c*BW +: BW] = (c == 0) ? a : b;
    return v;
  endfunction

  task automatic chk(input string name, input vec_w act, input vec_w exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input logic rst, vld, acc, fl, by, re, po,
                   input logic [15:0] in0, in1,
                   input logic ev, input logic [15:0] e0, e1, input logic es);
    vec_t r;
    r = '{rst, vld, acc, fl, by, re, po, in0, in1, ev, e0, e1, es};
    vecs.push_back(r);
  endtask

  initial begin
    vec_t r;
    vec_w exp;
    //  rst vld acc fl by re po  in0      in1       ev e0       e1       es
    v(1, 0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    0, 16'h0,    16'h0,    0);
    // accumulate then flush, then flush again to see a cleared accumulator
    v(0, 1, 1, 0, 0, 0, 0, 16'h0003, 16'h0003, 0, 16'h0,    16'h0,    0);
    v(0, 1, 1, 0, 0, 0, 0, 16'h0005, 16'h0005, 0, 16'h0,    16'h0,    0);
    v(0, 1, 1, 0, 0, 0, 0, 16'hFFFE, 16'hFFFE, 0, 16'h0,    16'h0,    0);
    v(0, 1, 0, 1, 0, 0, 0, 16'h0,    16'h0,    1, 16'h0006, 16'h0006, 0);
    v(0, 1, 0, 1, 0, 0, 0, 16'h0,    16'h0,    1, 16'h0,    16'h0,    0);
    // ReLU bypass leaves the accumulator alone
    v(0, 1, 1, 0, 0, 0, 0, 16'h0007, 16'h0007, 0, 16'h0,    16'h0,    0);
    v(0, 1, 0, 0, 1, 1, 0, 16'hFF00, 16'h0010, 1, 16'h0,    16'h0010, 0);
    v(0, 1, 0, 1, 0, 0, 0, 16'h0,    16'h0,    1, 16'h0007, 16'h0007, 0);
    v(0, 1, 1, 0, 0, 0, 0, 16'hFFF0, 16'h0003, 0, 16'h0,    16'h0,    0);
    v(0, 1, 0, 1, 0, 1, 0, 16'h0,    16'h0,    1, 16'h0,    16'h0003, 0);
    // positive saturation, sticky flag, idle cycle ignored
    v(0, 1, 1, 0, 0, 0, 0, 16'h7FF0, 16'h7FF0, 0, 16'h0,    16'h0,    0);
    v(0, 1, 1, 0, 0, 0, 0, 16'h0020, 16'h0020, 0, 16'h0,    16'h0,    1);
    v(0, 1, 0, 1, 0, 0, 0, 16'h0,    16'h0,    1, 16'h7FFF, 16'h7FFF, 1);
    v(0, 0, 1, 1, 1, 0, 0, 16'h0005, 16'h0005, 0, 16'h0,    16'h0,    1);
    // flush with acc, and bypass priority over flush/acc
    v(0, 1, 1, 0, 0, 0, 0, 16'h0002, 16'h0002, 0, 16'h0,    16'h0,    1);
    v(0, 1, 1, 1, 0, 0, 0, 16'h0003, 16'h0003, 1, 16'h0005, 16'h0005, 1);
    v(0, 1, 1, 0, 0, 0, 0, 16'h0004, 16'h0004, 0, 16'h0,    16'h0,    1);
    v(0, 1, 1, 1, 1, 0, 0, 16'h0009, 16'h0009, 1, 16'h0009, 16'h0009, 1);
    v(0, 1, 0, 1, 0, 0, 0, 16'h0,    16'h0,    1, 16'h0004, 16'h0004, 1);
    // pooling windows, signed compare, ReLU before pooling
    v(0, 1, 0, 0, 1, 0, 1, 16'h0004, 16'h0004, 0, 16'h0,    16'h0,    1);
    v(0, 1, 0, 0, 1, 0, 1, 16'hFFFF, 16'hFFFF, 1, 16'h0004, 16'h0004, 1);
    v(0, 1, 0, 0, 1, 0, 1, 16'hFFF0, 16'h0005, 0, 16'h0,    16'h0,    1);
    v(0, 1, 0, 0, 1, 0, 1, 16'hFFF8, 16'h0003, 1, 16'hFFF8, 16'h0005, 1);
    v(0, 1, 0, 0, 1, 1, 1, 16'hFFF0, 16'h0002, 0, 16'h0,    16'h0,    1);
    v(0, 1, 0, 0, 1, 1, 1, 16'hFFF8, 16'h0001, 1, 16'h0,    16'h0002, 1);
    // partial window abort, then a fresh window
    v(0, 1, 0, 0, 1, 0, 1, 16'h0100, 16'h0100, 0, 16'h0,    16'h0,    1);
    v(0, 1, 0, 0, 1, 0, 0, 16'h0009, 16'h0009, 1, 16'h0009, 16'h0009, 1);
    v(0, 1, 0, 0, 1, 0, 1, 16'h0002, 16'h0002, 0, 16'h0,    16'h0,    1);
    v(0, 1, 0, 0, 1, 0, 1, 16'h0001, 16'h0001, 1, 16'h0002, 16'h0002, 1);
    // accumulate-only cycle inside a window does not advance it
    v(0, 1, 0, 0, 1, 0, 1, 16'h0003, 16'h0003, 0, 16'h0,    16'h0,    1);
    v(0, 1, 1, 0, 0, 0, 1, 16'h0001, 16'h0001, 0, 16'h0,    16'h0,    1);
    v(0, 1, 0, 0, 1, 0, 1, 16'h0002, 16'h0002, 1, 16'h0003, 16'h0003, 1);
    v(0, 1, 0, 1, 0, 0, 0, 16'h0,    16'h0,    1, 16'h0001, 16'h0001, 1);
    // invalid cycle inside a window keeps the window
    v(0, 1, 0, 0, 1, 0, 1, 16'h0005, 16'h0005, 0, 16'h0,    16'h0,    1);
    v(0, 0, 0, 1, 1, 0, 0, 16'h0007, 16'h0007, 0, 16'h0,    16'h0,    1);
    v(0, 1, 0, 0, 1, 0, 1, 16'h0006, 16'h0006, 1, 16'h0006, 16'h0006, 1);
    // reset mid-accumulation and mid-window
    v(0, 1, 1, 0, 0, 0, 0, 16'h0010, 16'h0010, 0, 16'h0,    16'h0,    1);
    v(0, 1, 0, 0, 1, 0, 1, 16'h0050, 16'h0050, 0, 16'h0,    16'h0,    1);
    v(1, 1, 1, 1, 0, 0, 1, 16'h0011, 16'h0011, 0, 16'h0,    16'h0,    0);
    v(0, 1, 0, 1, 0, 0, 0, 16'h0,    16'h0,    1, 16'h0,    16'h0,    0);
    v(0, 1, 0, 0, 1, 0, 1, 16'h0001, 16'h0001, 0, 16'h0,    16'h0,    0);
    v(0, 1, 0, 0, 1, 0, 1, 16'h0,    16'h0,    1, 16'h0001, 16'h0001, 0);
    // negative saturation
    v(0, 1, 1, 0, 0, 0, 0, 16'h8000, 16'h8000, 0, 16'h0,    16'h0,    0);
    v(0, 1, 1, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 16'h0,    16'h0,    1);
    v(0, 1, 0, 1, 0, 0, 0, 16'h0,    16'h0,    1, 16'h8000, 16'h8000, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      r = vecs[i];
      reset             = r.rst;
      bus.valid_i       = r.vld;
      bus.acc_i         = r.acc;
      bus.flush_i       = r.fl;
      bus.psum_bypass_i = r.by;
      bus.relu_en_i     = r.re;
      bus.max_pool_en_i = r.po;
      bus.psum_in       = mk(r.in0, r.in1);
      if (r.rst) begin
        sb.delete();
        last_out = '0;
      end
      if (r.ev) sb.push_back(mk(r.e0, r.e1));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_valid", i), vec_w'(bus.out_valid_o), vec_w'(r.ev));
      chk($sformatf("row%0d sat", i), vec_w'(bus.sat_o), vec_w'(r.es));
      if (bus.out_valid_o && sb.size() > 0) begin
        exp = sb.pop_front();
        chk($sformatf("row%0d psum_out", i), bus.psum_out, exp);
        last_out = exp;
      end else if (!bus.out_valid_o) begin
        chk($sformatf("row%0d psum_out hold", i), bus.psum_out, last_out);
      end
    end

    chk("scoreboard drained", vec_w'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
